// File: rtl/data_memory_responder.sv
// Data-memory bus responder: word array with byte-lane writes, a configurable
// number of wait states before acceptance, and a configurable read latency
// ending in a one-cycle bus_valid pulse.
module data_memory_responder #(
  parameter int DEPTH        = 4096,
  parameter int WAIT_STATES  = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic        bus_wait_req,
  output logic        bus_valid,
  output logic [31:0] bus_read_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Counter preloads: the stall counter counts down to the accept cycle, the
  // latency counter counts the READ_WAIT cycles before RESPOND.
  localparam logic [3:0] LP_STALL_LOAD = (WAIT_STATES > 0)  ? 4'(WAIT_STATES - 1)  : 4'd0;
  localparam logic [3:0] LP_LAT_LOAD   = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;
  localparam bit         LP_NO_WAIT    = (WAIT_STATES == 0);
  localparam bit         LP_ONE_CYCLE  = (READ_LATENCY <= 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STALL,
    S_READ_WAIT,
    S_RESPOND
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_stall_cnt;
  logic [3:0]       w_stall_cnt_next;
  logic [3:0]       r_lat_cnt;
  logic [3:0]       w_lat_cnt_next;
  logic             w_req;
  logic             w_accept;
  logic             w_accept_wr;
  logic             w_accept_rd;
  logic             w_wait_req;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      r_rdata;
  logic [31:0]      r_mem [DEPTH];
  logic             w_unused;

  assign w_req       = bus_read_enable | bus_write_enable;
  assign w_idx       = bus_address[IDX_W+1:2];
  assign w_accept_wr = w_accept & bus_write_enable;
  assign w_accept_rd = w_accept & ~bus_write_enable;

  // Address bits outside the word index are deliberately ignored (aliasing).
  assign w_unused = &{1'b0, bus_address[31:IDX_W+2], bus_address[1:0]};

  // State and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= '0;
      r_lat_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_stall_cnt <= w_stall_cnt_next;
      r_lat_cnt   <= w_lat_cnt_next;
    end
  end

  // Next-state, counter update, acceptance and wait-request decode.
  always_comb begin
    w_state_next     = r_state;
    w_stall_cnt_next = r_stall_cnt;
    w_lat_cnt_next   = r_lat_cnt;
    w_accept         = 1'b0;
    w_wait_req       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_wait_req = LP_NO_WAIT ? 1'b0 : w_req;
        if (w_req) begin
          if (LP_NO_WAIT) begin
            w_accept = 1'b1;
          end else begin
            w_state_next     = S_STALL;
            w_stall_cnt_next = LP_STALL_LOAD;
          end
        end
      end
      S_STALL: begin
        w_wait_req = (r_stall_cnt != 4'd0);
        if (!w_req) begin
          w_state_next = S_IDLE;
        end else if (r_stall_cnt != 4'd0) begin
          w_stall_cnt_next = r_stall_cnt - 4'd1;
        end else begin
          w_accept = 1'b1;
        end
      end
      S_READ_WAIT: begin
        w_wait_req = 1'b1;
        if (r_lat_cnt == 4'd0) begin
          w_state_next = S_RESPOND;
        end else begin
          w_lat_cnt_next = r_lat_cnt - 4'd1;
        end
      end
      S_RESPOND: begin
        w_wait_req   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Write wins when both enables are high; a read leads to the response path.
    if (w_accept) begin
      if (bus_write_enable) begin
        w_state_next = S_IDLE;
      end else if (LP_ONE_CYCLE) begin
        w_state_next = S_RESPOND;
      end else begin
        w_state_next   = S_READ_WAIT;
        w_lat_cnt_next = LP_LAT_LOAD;
      end
    end
  end

  // Byte-lane writes into the word array (not reset).
  always_ff @(posedge clock) begin
    if (w_accept_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus_byte_enable[i]) begin
          r_mem[w_idx][8*i +: 8] <= bus_write_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read captured at the acceptance edge and held until RESPOND;
  // no write can be accepted while a read is pending, so the word is stable.
  always_ff @(posedge clock) begin
    if (w_accept_rd) begin
      r_rdata <= r_mem[w_idx];
    end
  end

  assign bus_wait_req  = w_wait_req;
  assign bus_valid     = (r_state == S_RESPOND);
  assign bus_read_data = bus_valid ? r_rdata : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomised bench for data_memory_responder: two instances (no wait states /
// single-cycle latency, and 3 wait states / 4-cycle latency), a behavioural
// memory model, and a response scoreboard checked by a separate monitor.
module tb_data_memory_responder;

  localparam int DEPTH_T = 16;
  localparam int WS0 = 0, RL0 = 1;
  localparam int WS1 = 3, RL1 = 4;

  typedef struct {
    int          inst;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [3:0]  be      [2];
  logic        rd_en   [2];
  logic        wr_en   [2];
  logic        wait_req[2];
  logic        valid   [2];
  logic [31:0] rdata   [2];

  int          checks;
  int          fails;
  int unsigned cyc;
  exp_t        exp_q[$];
  logic [31:0] mdl [2][DEPTH_T];

  data_memory_responder #(.DEPTH(DEPTH_T), .WAIT_STATES(WS0), .READ_LATENCY(RL0)) dut0 (
    .clock(clk), .reset(rst_n), .bus_address(addr[0]), .bus_write_data(wdata[0]),
    .bus_byte_enable(be[0]), .bus_read_enable(rd_en[0]), .bus_write_enable(wr_en[0]),
    .bus_wait_req(wait_req[0]), .bus_valid(valid[0]), .bus_read_data(rdata[0]));

  data_memory_responder #(.DEPTH(DEPTH_T), .WAIT_STATES(WS1), .READ_LATENCY(RL1)) dut1 (
    .clock(clk), .reset(rst_n), .bus_address(addr[1]), .bus_write_data(wdata[1]),
    .bus_byte_enable(be[1]), .bus_read_enable(rd_en[1]), .bus_write_enable(wr_en[1]),
    .bus_wait_req(wait_req[1]), .bus_valid(valid[1]), .bus_read_data(rdata[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int k);
    return (k == 0) ? WS0 : WS1;
  endfunction

  function automatic int rl_of(input int k);
    return (k == 0) ? RL0 : RL1;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH_T);
  endfunction

  function automatic void chk(input string name, input int k,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s dut%0d actual=0x%08h required=0x%08h", name, k, act, req);
    end
  endfunction

  // Model: byte-enabled write into the reference array.
  function automatic void model_write(input int k, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] b);
    int i;
    i = idx_of(a);
    for (int l = 0; l < 4; l++)
      if (b[l]) mdl[k][i][8*l +: 8] = d[8*l +: 8];
  endfunction

  // Monitor: every response must match the oldest expectation, in the right cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (valid[k] === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].inst != k) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid dut%0d actual=1 required=0 cycle=%0d", k, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("read_data", k, rdata[k], e.data);
          chk("valid_cycle", k, 32'(cyc), 32'(e.cyc));
          chk("wait_in_respond", k, 32'(wait_req[k]), 32'd1);
        end
      end else begin
        chk("valid_low", k, 32'(valid[k]), 32'd0);
        chk("data_zero_when_idle", k, rdata[k], 32'd0);
      end
    end
  end

  task automatic clear_inputs(input int k);
    rd_en[k] = 1'b0;
    wr_en[k] = 1'b0;
    addr[k]  = '0;
    wdata[k] = '0;
    be[k]    = '0;
  endtask

  // Issue one request from IDLE; optionally drop it after drop_after stalled cycles.
  task automatic do_req(input int k, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input int drop_after);
    int stall;
    bit accepted;
    bit dropped;
    stall    = 0;
    accepted = 0;
    dropped  = 0;
    rd_en[k] = rd;
    wr_en[k] = wr;
    addr[k]  = a;
    wdata[k] = d;
    be[k]    = b;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (wait_req[k] === 1'b0) begin
        accepted = 1;
        break;
      end
      stall++;
      if (drop_after > 0 && stall == drop_after) begin
        dropped = 1;
        break;
      end
    end
    if (accepted) begin
      chk("stall_cycles", k, 32'(stall), 32'(ws_of(k)));
      if (wr) begin
        model_write(k, a, d, b);
      end else begin
        exp_t e;
        e.inst = k;
        e.data = mdl[k][idx_of(a)];
        e.cyc  = cyc + rl_of(k);
        exp_q.push_back(e);
      end
    end else if (!dropped) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout dut%0d actual=stalled required=accepted", k);
    end
    @(posedge clk);
    #1;
    clear_inputs(k);
    if (dropped) begin
      @(posedge clk);
      #1;
    end
    if (accepted && !wr) begin
      for (int n = 0; n < 40; n++) begin
        if (exp_q.size() == 0) break;
        @(posedge clk);
        #1;
      end
      checks++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL response_timeout dut%0d actual=pending required=delivered", k);
        exp_q.delete();
      end
    end
  endtask

  // Fill every word so later reads are fully defined.
  task automatic init_mem(input int k);
    for (int i = 0; i < DEPTH_T; i++)
      do_req(k, 1'b0, 1'b1, (32'(i) * 4) | ($urandom << 6), $urandom, 4'hF, 0);
  endtask

  task automatic random_ops(input int k, input int n_ops);
    for (int n = 0; n < n_ops; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3)
        do_req(k, 1'b1, 1'b0, $urandom, $urandom, 4'($urandom), 0);
      else if (op <= 7)
        do_req(k, 1'b0, 1'b1, $urandom, $urandom, 4'($urandom), 0);
      else if (op == 8)
        do_req(k, 1'b1, 1'b1, $urandom, $urandom, 4'($urandom), 0);
      else if (ws_of(k) > 1)
        do_req(k, 1'b0, 1'b1, $urandom, $urandom, 4'hF, $urandom_range(1, ws_of(k) - 1));
      else
        do_req(k, 1'b1, 1'b0, $urandom, $urandom, 4'hF, 0);
    end
  endtask

  // Read accepted, then reset while it waits: no response may ever appear.
  task automatic reset_abort(input int k, input logic [31:0] a);
    bit accepted;
    accepted = 0;
    rd_en[k] = 1'b1;
    addr[k]  = a;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (wait_req[k] === 1'b0) begin
        accepted = 1;
        break;
      end
    end
    chk("abort_read_accepted", k, 32'(accepted), 32'd1);
    @(posedge clk);
    #1;
    clear_inputs(k);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("wait_after_abort", k, 32'(wait_req[k]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    fails  = 0;
    cyc    = 0;
    rst_n  = 1'b1;
    for (int k = 0; k < 2; k++) clear_inputs(k);
    #1;
    rst_n    = 1'b0;
    rd_en[0] = 1'b1;
    rd_en[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) clear_inputs(k);
    @(negedge clk);
    chk("idle_wait_req", 0, 32'(wait_req[0]), 32'd0);
    chk("idle_wait_req", 1, 32'(wait_req[1]), 32'd0);
    @(posedge clk);
    #1;

    // Instance 0: no wait states, single-cycle read latency.
    init_mem(0);
    do_req(0, 1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'hF, 0);
    do_req(0, 1'b0, 1'b1, 32'h42, 32'h00AB_0000, 4'b0100, 0);
    chk("lane_merge_model", 0, mdl[0][idx_of(32'h40)], 32'h11AB_3344);
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0);
    do_req(0, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, 0);
    do_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0);
    do_req(0, 1'b1, 1'b1, 32'h8, 32'hCAFE_F00D, 4'hF, 0);
    do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 0);
    random_ops(0, 150);

    // Instance 1: three wait states, four-cycle read latency.
    init_mem(1);
    do_req(1, 1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'hF, 0);
    do_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0);
    do_req(1, 1'b0, 1'b1, 32'h4, 32'h5A5A_A5A5, 4'hF, 2);
    do_req(1, 1'b0, 1'b1, 32'h4, 32'h0F0F_0F0F, 4'hF, 1);
    do_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 0);
    reset_abort(1, 32'h40);
    do_req(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0);
    random_ops(1, 150);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 0, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Bus-side responder (slave) for the core's data-memory bus: accepts read/write requests, stalls via bus_wait_req, returns read data with a one-cycle bus_valid pulse.
- Backs the bus with an on-chip word array with byte-lane writes.
- Read latency and wait states are configurable, so the core's load/store path can be exercised against slow memory in simulation and on FPGA.

Parameters:
- DEPTH, 4096, number of 32-bit words; must be a power of two, >= 2.
- WAIT_STATES, 0, cycles bus_wait_req is held high on a new request before acceptance (0..15).
- READ_LATENCY, 1, cycles from read acceptance to the bus_valid pulse (1..15).

Ports:
- clock  input  1  core clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- bus_address  input  32  byte address; word index = bus_address[log2(DEPTH)+1:2]; bits [1:0] and bits above the index are ignored (aliasing).
- bus_write_data  input  32  write data, already lane-aligned by the initiator.
- bus_byte_enable  input  4  byte lanes to write; ignored on reads.
- bus_read_enable  input  1  read request.
- bus_write_enable  input  1  write request.
- bus_wait_req  output  1  stall: a request is accepted only in a cycle where it is high and this is low.
- bus_valid  output  1  one-cycle pulse; bus_read_data is valid in that cycle.
- bus_read_data  output  32  full aligned word; initiator performs lane shift and sign-extension.

Behaviour:
- States: IDLE, STALL, READ_WAIT, RESPOND.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; stall and latency counters clear.
  - bus_valid=0 and bus_read_data=0.
  - Memory contents are not cleared.
  - Reset mid-stall or mid-read drops the pending transaction; no bus_valid is issued for it.
- Request: req = bus_read_enable | bus_write_enable. If both are high, the write takes precedence and no read response follows.
- bus_wait_req (combinational from state, counter and req):
  - IDLE: 0 if WAIT_STATES=0; otherwise equal to req.
  - STALL: 1 while the counter > 0, 0 when the counter = 0.
  - READ_WAIT and RESPOND: 1.
- IDLE:
  - No req: stay IDLE.
  - req with WAIT_STATES=0: accept this cycle.
  - req with WAIT_STATES>0: load counter = WAIT_STATES-1, go to STALL.
- STALL:
  - Counter decrements each cycle while > 0.
  - Counter = 0 with req still high: accept this cycle.
  - req drops at any point: return to IDLE without side effects.
  - A new request therefore sees exactly WAIT_STATES cycles of bus_wait_req=1 before the accept cycle.
- Accepted write:
  - At that edge, for each lane i with bus_byte_enable[i]=1: mem[idx][8i+7:8i] <= bus_write_data[8i+7:8i]. Other lanes are unchanged.
  - Next state IDLE. No bus_valid.
  - Back-to-back writes with WAIT_STATES=0 sustain one write per cycle.
- Accepted read:
  - Word index latched at the acceptance edge; the word read is the memory content at that edge.
  - READ_LATENCY=1: go directly to RESPOND.
  - READ_LATENCY>1: go to READ_WAIT with latency counter = READ_LATENCY-2; decrement each cycle; go to RESPOND when it is 0.
  - Read acceptance at edge T puts the bus_valid pulse in cycle T+READ_LATENCY.
- RESPOND:
  - bus_valid=1 and bus_read_data=mem[latched idx] for exactly one cycle, then IDLE.
  - Requests in this cycle are stalled (bus_wait_req=1) and are seen fresh in IDLE on the next cycle.
- bus_read_data is 0 whenever bus_valid=0.
- Pending read: bus_read_enable/bus_write_enable are ignored in READ_WAIT; no second read is ever in flight.
- Storage: memory is not reset; there is no initial-content requirement.
- Tooling: implementation must infer block RAM or registered reads. Extra pipeline registers are allowed only if the stated cycle timing is preserved.

Test Plan:
- Reset and idle: reset=0 for 3 cycles while bus_read_enable=1 -> bus_valid=0, bus_read_data=0; after release with WAIT_STATES=0 and no req -> bus_wait_req=0.
- Byte-lane write: full write 0x11223344 to 0x40, then bus_byte_enable=4'b0100 with data 0x00AB0000 to 0x42 -> read of 0x40 returns 0x11AB3344.
- Default read timing: WAIT_STATES=0, READ_LATENCY=1, read of 0x40 accepted at edge T -> bus_valid high in cycle T+1 only, data 0x11AB3344; bus_wait_req=1 in cycle T+1.
- Stall and latency counting: WAIT_STATES=3, READ_LATENCY=4, read of 0x40 raised at cycle 0 -> bus_wait_req=1 in cycles 0-2, accepted in cycle 3, bus_valid in cycle 7.
- Aliasing and precedence:
  - DEPTH=16: write 0xDEADBEEF to 0x0 -> read of 0x40 returns 0xDEADBEEF.
  - bus_read_enable=1 and bus_write_enable=1 together -> write performed, no bus_valid.
- Abort cases:
  - Reset asserted in READ_WAIT -> no bus_valid ever appears for that read.
  - Request dropped during STALL -> IDLE, memory unchanged.
